// File: rtl/fc_weight_loader.sv
// Write-side loader for the fully-connected weight memory: packs a serial
// stream of signed weights into LANES-wide rows and writes NUM_ROWS rows.
module fc_weight_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 16,
  parameter int NUM_ROWS   = 27,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          in_ready,
  output logic                          fullyconnected_WrEn,
  output logic [ADDR_WIDTH-1:0]         address_w,
  output logic [DATA_WIDTH*LANES-1:0]   fullyconnected_weights_input,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    state_dbg
);

  // Handshake: a beat transfers on a posedge where in_valid and in_ready are
  // both high; in_ready is registered and is high exactly while in FILL.
  localparam int LANE_W = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t                state, state_next;
  logic [LANE_W-1:0]     lane_cnt;
  logic [ADDR_WIDTH-1:0] row_cnt;
  logic [DATA_WIDTH-1:0] lanes [LANES];
  logic                  accept, last_lane, last_row;

  assign state_dbg = state;

  always_comb begin
    accept     = (state == FILL) && in_valid && !abort;
    last_lane  = (lane_cnt == LANE_W'(LANES - 1));
    last_row   = (row_cnt == ADDR_WIDTH'(NUM_ROWS - 1));
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FILL;
      FILL:    if (accept && last_lane) state_next = WRITE;
      WRITE:   state_next = last_row ? DONE : FILL;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // abort overrides every other transition, including a pending write
    if (abort) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_cnt <= '0;
      row_cnt  <= '0;
    end else if (abort) begin
      lane_cnt <= '0;
      row_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          lane_cnt <= '0;
          row_cnt  <= '0;
        end
        FILL:  if (accept) lane_cnt <= last_lane ? '0 : lane_cnt + 1'b1;
        WRITE: if (!last_row) row_cnt <= row_cnt + 1'b1;
        DONE:  row_cnt <= '0;
        default: ;
      endcase
    end
  end

  // Lanes only change on accepted beats, so the bus is frozen through WRITE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < LANES; k++) lanes[k] <= '0;
    end else if (accept) begin
      lanes[lane_cnt] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready            <= 1'b0;
      busy                <= 1'b0;
      fullyconnected_WrEn <= 1'b1;
      done                <= 1'b0;
      address_w           <= '0;
    end else begin
      in_ready            <= (state_next == FILL);
      busy                <= (state_next == FILL) || (state_next == WRITE);
      fullyconnected_WrEn <= (state_next != WRITE);
      done                <= (state_next == DONE);
      if (state_next == WRITE) address_w <= row_cnt;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_pack
    assign fullyconnected_weights_input[g*DATA_WIDTH +: DATA_WIDTH] = lanes[g];
  end

endmodule

// File: tb/tb_fc_weight_loader.sv
// Directed bench for fc_weight_loader: a negedge memory model captures rows
// and the expected row image is rebuilt from the stream pattern.
module tb_fc_weight_loader;

  localparam int DW    = 8;
  localparam int LANES = 16;
  localparam int ROWS  = 27;
  localparam int AW    = 5;
  localparam int BEATS = LANES * ROWS;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic                in_valid = 1'b0;
  logic [DW-1:0]       in_data = '0;
  logic                in_ready;
  logic                wr_en;
  logic [AW-1:0]       address_w;
  logic [DW*LANES-1:0] bus;
  logic                busy;
  logic                done;
  logic [1:0]          state_dbg;

  fc_weight_loader #(.DATA_WIDTH(DW), .LANES(LANES), .NUM_ROWS(ROWS), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .fullyconnected_WrEn(wr_en), .address_w(address_w),
    .fullyconnected_weights_input(bus), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model samples on negedge, like the real weight RAM.
  logic [DW*LANES-1:0] mem [ROWS];
  logic [AW-1:0]       addr_log [$];
  int write_cnt = 0, done_cnt = 0, done_cyc = 0, ready_in_write = 0;

  always @(negedge clk) begin
    if (rst && !wr_en) begin
      if (int'(address_w) < ROWS) mem[address_w] = bus;
      addr_log.push_back(address_w);
      write_cnt++;
      if (in_ready) ready_in_write++;
    end
    if (rst && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  logic [AW-1:0] exp_q [$];
  int n_pass = 0, n_total = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] beat_data(input int i, input bit sgn);
    if (sgn && i < LANES) begin
      case (i)
        0:       return 8'h80;
        1:       return 8'h7F;
        2:       return 8'hFF;
        default: return 8'h00;
      endcase
    end
    return DW'(i % 256);
  endfunction

  function automatic logic [DW*LANES-1:0] exp_row(input int r, input bit sgn);
    logic [DW*LANES-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*DW +: DW] = beat_data(LANES*r + k, sgn);
    return v;
  endfunction

  task automatic send_beat(input logic [DW-1:0] d, input int gap_pct);
    int  n = 0;
    bit  got = 1'b0;
    while (int'($urandom_range(99)) < gap_pct) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    do begin
      got = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!got && n < 1000);
    in_valid = 1'b0;
    if (!got) chk("beat_timeout", 0, 1);
  endtask

  task automatic feed(input int n, input int gap_pct, input bit sgn, input int start_at);
    for (int i = 0; i < n; i++) begin
      start = (i == start_at);
      send_beat(beat_data(i, sgn), gap_pct);
      start = 1'b0;
    end
  endtask

  task automatic full_load(input int gap_pct, input bit sgn, input int start_at,
                           input bit start_in_done, output int s_cyc);
    int wb, db, ab;
    wb = write_cnt; db = done_cnt; ab = addr_log.size();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s_cyc = cyc;
    feed(BEATS, gap_pct, sgn, start_at);
    @(posedge clk); #1;
    chk("done_pulse", done, 1);
    if (start_in_done) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("idle_after_done", busy, 0);
    chk("write_count", write_cnt - wb, ROWS);
    chk("done_count", done_cnt - db, 1);
    exp_q = {};
    for (int r = 0; r < ROWS; r++) exp_q.push_back(AW'(r));
    for (int i = 0; i < ROWS; i++) chk("addr_order", addr_log[ab + i], exp_q.pop_front());
    for (int r = 0; r < ROWS; r++) chk("row_image", mem[r], exp_row(r, sgn));
  endtask

  initial begin
    int s_cyc, wb, db, sv;

    // Reset state
    #12;
    chk("rst_wren", wr_en, 1);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", address_w, 0);
    chk("rst_bus", bus, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Async reset in the middle of row 3
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    feed(3*LANES + 5, 0, 1'b0, -1);
    chk("pre_reset_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_wren", wr_en, 1);
    chk("midrst_ready", in_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_addr", address_w, 0);
    chk("midrst_state", state_dbg, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Full load, no gaps; done in the 461st cycle counting the start cycle as 1
    full_load(0, 1'b0, -1, 1'b0, s_cyc);
    chk("done_cycle", done_cyc - s_cyc, 459);

    // Random 50% gaps
    full_load(50, 1'b0, -1, 1'b0, s_cyc);
    chk("ready_low_in_write", ready_in_write, 0);

    // Signed extremes in row 0
    full_load(0, 1'b1, -1, 1'b0, s_cyc);
    sv = $signed(mem[0][7:0]);
    chk("signed_lane0", sv, -128);
    sv = $signed(mem[0][23:16]);
    chk("signed_lane2", sv, -1);

    // start pulsed during FILL and during DONE
    full_load(0, 1'b0, 40, 1'b1, s_cyc);

    // abort at row 5 lane 7
    wb = write_cnt; db = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    feed(5*LANES + 7, 0, 1'b0, -1);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    abort    = 1'b1;
    @(posedge clk); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("abort_state", state_dbg, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", in_ready, 0);
    chk("abort_wren", wr_en, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_writes", write_cnt - wb, 5);
    chk("abort_no_done", done_cnt - db, 0);
    chk("abort_last_addr", addr_log[addr_log.size()-1], 4);
    full_load(20, 1'b0, -1, 1'b0, s_cyc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
